// File: rtl/cg_iteration_controller.sv
// CG solver loop controller: sequences the Alu resets each iteration and terminates on convergence, cap, NaN/Inf or protocol error.
// Optional stagnation detection (status 5, parameter stall_limit) is built when CG_STAGNATION_EN is defined.
module cg_iteration_controller #(
    parameter int unsigned              element_width  = 32,
    parameter logic [element_width-1:0] tolerance      = 32'h283424DC,
    parameter int unsigned              max_iterations = 1000,
    parameter int unsigned              iter_width     = 16,
    parameter int unsigned              restart_gap    = 2
`ifdef CG_STAGNATION_EN
    ,
    parameter int unsigned              stall_limit    = 8
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic                     abort,
    input  logic [element_width-1:0] rsnew,
    input  logic                     rsnew_valid,
    input  logic                     iter_done,
    output logic                     reset_vXv1,
    output logic                     reset_mXv1,
    output logic                     busy,
    output logic                     done,
    output logic [2:0]               status,
    output logic [iter_width-1:0]    iteration_count,
    output logic [element_width-1:0] rsnew_last
);

    localparam int unsigned MAX_EFF = (max_iterations == 0) ? 1 : max_iterations;
    localparam int unsigned GAP_EFF = (restart_gap == 0) ? 1 : restart_gap;
    localparam logic [30:0] TOL_MAG = tolerance[30:0];

    localparam logic [2:0] ST_NONE  = 3'd0;
    localparam logic [2:0] ST_CONV  = 3'd1;
    localparam logic [2:0] ST_MAXIT = 3'd2;
    localparam logic [2:0] ST_NAN   = 3'd3;
    localparam logic [2:0] ST_PROTO = 3'd4;
`ifdef CG_STAGNATION_EN
    localparam logic [2:0]  ST_STALL  = 3'd5;
    localparam int unsigned STALL_EFF = (stall_limit == 0) ? 1 : stall_limit;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_RUN, S_CHECK, S_WAIT_UPDATE, S_RESTART, S_FINISH
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0]               status_q, status_d;
    logic [iter_width-1:0]    iter_q, iter_d;
    logic [element_width-1:0] last_q, last_d;
    logic                     pend_q, pend_d;
    logic [15:0]              gap_q, gap_d;
    logic                     strobe_q, strobe_d;
    logic                     busy_state;
    logic                     at_cap;
`ifdef CG_STAGNATION_EN
    logic [30:0]              min_q, min_d;
    logic [15:0]              stall_q, stall_d;
`endif

    function automatic logic [iter_width-1:0] sat_inc(input logic [iter_width-1:0] v);
        return (&v) ? v : v + iter_width'(1);
    endfunction

    assign busy_state = (state_q != S_IDLE) && (state_q != S_FINISH);
    assign at_cap     = (33'(iter_q) + 33'd1) >= 33'(MAX_EFF);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            status_q <= ST_NONE;
            iter_q   <= '0;
            last_q   <= '0;
            pend_q   <= 1'b0;
            gap_q    <= '0;
            strobe_q <= 1'b1;
`ifdef CG_STAGNATION_EN
            min_q    <= '1;
            stall_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            iter_q   <= iter_d;
            last_q   <= last_d;
            pend_q   <= pend_d;
            gap_q    <= gap_d;
            strobe_q <= strobe_d;
`ifdef CG_STAGNATION_EN
            min_q    <= min_d;
            stall_q  <= stall_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        iter_d   = iter_q;
        last_d   = last_q;
        pend_d   = pend_q;
        gap_d    = gap_q;
        strobe_d = strobe_q;
`ifdef CG_STAGNATION_EN
        min_d    = min_q;
        stall_d  = stall_q;
`endif
        if (abort && busy_state) begin
            status_d = ST_PROTO;
            state_d  = S_FINISH;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        status_d = ST_NONE;
                        iter_d   = '0;
                        pend_d   = 1'b0;
                        state_d  = S_LAUNCH;
`ifdef CG_STAGNATION_EN
                        min_d    = '1;
                        stall_d  = '0;
`endif
                    end
                end
                S_LAUNCH: state_d = S_RUN;
                S_RUN: begin
                    if (rsnew_valid) begin
                        last_d  = rsnew;
                        pend_d  = iter_done;
                        state_d = S_CHECK;
                    end else if (iter_done) begin
                        status_d = ST_PROTO;
                        state_d  = S_FINISH;
                    end
                end
                S_CHECK: begin
                    // An update finishing while we evaluate must not be lost.
                    pend_d = pend_q | iter_done;
                    if (&last_q[30:23]) begin
                        status_d = ST_NAN;
                        state_d  = S_FINISH;
                    end else if (last_q[30:0] <= TOL_MAG) begin
                        status_d = ST_CONV;
                        state_d  = S_FINISH;
                    end else begin
`ifdef CG_STAGNATION_EN
                        if (last_q[30:0] < min_q) begin
                            min_d   = last_q[30:0];
                            stall_d = '0;
                        end else begin
                            stall_d = (&stall_q) ? stall_q : stall_q + 16'd1;
                        end
                        if (32'(stall_d) >= STALL_EFF) begin
                            status_d = ST_STALL;
                            state_d  = S_FINISH;
                        end else if (at_cap) begin
                            status_d = ST_MAXIT;
                            state_d  = S_FINISH;
                        end else begin
                            state_d = S_WAIT_UPDATE;
                        end
`else
                        if (at_cap) begin
                            status_d = ST_MAXIT;
                            state_d  = S_FINISH;
                        end else begin
                            state_d = S_WAIT_UPDATE;
                        end
`endif
                    end
                end
                S_WAIT_UPDATE: begin
                    if (rsnew_valid) begin
                        status_d = ST_PROTO;
                        state_d  = S_FINISH;
                    end else if (iter_done || pend_q) begin
                        pend_d  = 1'b0;
                        iter_d  = sat_inc(iter_q);
                        gap_d   = '0;
                        state_d = S_RESTART;
                    end
                end
                S_RESTART: begin
                    if (gap_q == 16'(GAP_EFF - 1)) state_d = S_LAUNCH;
                    else gap_d = gap_q + 16'd1;
                end
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
        if (state_d == S_FINISH) pend_d = 1'b0;
        // Strobes lag RESTART/LAUNCH by one cycle; termination raises them at once.
        if (state_d == S_FINISH || state_d == S_IDLE || state_q == S_RESTART) strobe_d = 1'b1;
        else if (state_q == S_LAUNCH) strobe_d = 1'b0;
    end

    always_comb begin
        reset_vXv1      = strobe_q;
        reset_mXv1      = strobe_q;
        busy            = busy_state;
        done            = (state_q == S_FINISH);
        status          = status_q;
        iteration_count = iter_q;
        rsnew_last      = last_q;
    end

endmodule

// File: tb/tb_cg_iteration_controller.sv
// Bench for cg_iteration_controller: directed scenarios plus random residual sequences against a reference model.
// Stagnation scenarios are included when CG_STAGNATION_EN is defined.
module tb_cg_iteration_controller;

    localparam int          MAXI    = 3;
    localparam int          GAP     = 2;
    localparam logic [31:0] TOL     = 32'h283424DC;
    localparam int unsigned TOL_MAG = 32'h283424DC;
`ifdef CG_STAGNATION_EN
    localparam int          STALL_L = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] rsnew = '0;
    logic        rsnew_valid = 1'b0;
    logic        iter_done = 1'b0;
    logic        reset_vXv1, reset_mXv1, busy, done;
    logic [2:0]  status;
    logic [15:0] iteration_count;
    logic [31:0] rsnew_last;

    int n_assert = 0;
    int n_fail = 0;
    int unsigned hist[$];
    logic [31:0] seq[$];

    cg_iteration_controller #(
        .max_iterations(MAXI),
        .restart_gap(GAP)
`ifdef CG_STAGNATION_EN
        ,
        .stall_limit(STALL_L)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .go(go),
        .abort(abort),
        .rsnew(rsnew),
        .rsnew_valid(rsnew_valid),
        .iter_done(iter_done),
        .reset_vXv1(reset_vXv1),
        .reset_mXv1(reset_mXv1),
        .busy(busy),
        .done(done),
        .status(status),
        .iteration_count(iteration_count),
        .rsnew_last(rsnew_last)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_reset_vXv1"}, 32'(reset_vXv1), 32'd1);
        chk({tag, "_reset_mXv1"}, 32'(reset_mXv1), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_status"}, 32'(status), 32'd0);
        chk({tag, "_count"}, 32'(iteration_count), 32'd0);
        chk({tag, "_rsnew_last"}, rsnew_last, 32'd0);
    endtask

    // Reference outcome of one check: NaN/Inf, convergence, stagnation, then the iteration cap.
    task automatic model_step(input logic [31:0] v, input int k, output logic [2:0] st);
        int unsigned m;
        m = v & 32'h7FFF_FFFF;
        if (m >= 32'h7F80_0000) st = 3'd3;
        else if (m <= TOL_MAG) st = 3'd1;
        else begin
            st = 3'd0;
`ifdef CG_STAGNATION_EN
            begin
                int unsigned best;
                int stall;
                hist.push_back(m);
                best = 32'hFFFF_FFFF;
                stall = 0;
                foreach (hist[i]) begin
                    if (hist[i] < best) begin
                        best = hist[i];
                        stall = 0;
                    end else begin
                        stall++;
                    end
                end
                if (stall >= STALL_L) st = 3'd5;
            end
`endif
            if (st == 3'd0 && k + 1 >= MAXI) st = 3'd2;
        end
    endtask

    task automatic start_solve;
        int n;
        hist.delete();
        go = 1'b1;
        tick;
        go = 1'b0;
        chk("go_busy", 32'(busy), 32'd1);
        chk("go_status", 32'(status), 32'd0);
        chk("go_count", 32'(iteration_count), 32'd0);
        n = 0;
        while (reset_vXv1 !== 1'b0 && n < 20) begin
            tick;
            n++;
        end
        chk("launch_timeout", 32'(n < 20), 32'd1);
    endtask

    task automatic feed(input logic [31:0] v, input bit same, inout int k, output bit term);
        logic [2:0] exp_st;
        int n, high;
        model_step(v, k, exp_st);
        rsnew = v;
        rsnew_valid = 1'b1;
        iter_done = same;
        tick;
        rsnew_valid = 1'b0;
        iter_done = 1'b0;
        chk("latch_rsnew", rsnew_last, v);
        term = (exp_st != 3'd0);
        if (term) begin
            chk("pre_done", 32'(done), 32'd0);
            tick;
            chk("done_pulse", 32'(done), 32'd1);
            chk("term_status", 32'(status), 32'(exp_st));
            chk("term_count", 32'(iteration_count), 32'(k));
            chk("fin_busy", 32'(busy), 32'd0);
            chk("fin_reset_vXv1", 32'(reset_vXv1), 32'd1);
            chk("fin_reset_mXv1", 32'(reset_mXv1), 32'd1);
            tick;
            chk("done_single", 32'(done), 32'd0);
            chk("status_hold", 32'(status), 32'(exp_st));
        end else begin
            if (!same) begin
                tick;
                iter_done = 1'b1;
                tick;
                iter_done = 1'b0;
            end
            n = 0;
            high = 0;
            while (n < 20) begin
                tick;
                n++;
                if (reset_vXv1) high++;
                else if (high > 0) break;
            end
            chk("gap_high", 32'(high), 32'(GAP));
            if (!same) chk("restart_latency", 32'(n + 1), 32'(GAP + 2));
            chk("run_status", 32'(status), 32'd0);
            k++;
            chk("iter_inc", 32'(iteration_count), 32'(k));
        end
    endtask

    task automatic run_seq(input bit same);
        int k;
        bit term;
        start_solve();
        k = 0;
        term = 1'b0;
        foreach (seq[i]) begin
            if (!term) feed(seq[i], same, k, term);
        end
        chk("seq_terminated", 32'(term), 32'd1);
    endtask

    function automatic logic [31:0] rand_val();
        logic [31:0] v;
        case ($urandom_range(0, 9))
            0:       v = 32'h7F80_0000 | 32'($urandom_range(1, 32'h007F_FFFF));
            1:       v = 32'h7F80_0000;
            2, 3:    v = 32'($urandom_range(0, TOL_MAG));
            4:       v = TOL + 32'($urandom_range(0, 1));
            default: v = 32'($urandom_range(TOL_MAG + 1, 32'h7F7F_FFFF));
        endcase
        v[31] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    initial begin
        int k;
        bit term;

        tick;
        tick;
        chk_reset_vals("rst");
        reset = 1'b0;
        tick;
        chk_reset_vals("rst_release");

        seq = '{32'h3F80_0000, 32'h2800_0000};
        run_seq(1'b0);
        chk("conv_status", 32'(status), 32'd1);
        chk("conv_count", 32'(iteration_count), 32'd1);

        seq = '{32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000};
        run_seq(1'b0);
`ifndef CG_STAGNATION_EN
        chk("maxit_status", 32'(status), 32'd2);
        chk("maxit_count", 32'(iteration_count), 32'd2);
`endif

        seq = '{32'h7FC0_0000};
        run_seq(1'b0);
        chk("nan_status", 32'(status), 32'd3);
        seq = '{32'h8000_0000};
        run_seq(1'b0);
        chk("negzero_status", 32'(status), 32'd1);
        seq = '{32'h7F80_0000};
        run_seq(1'b0);
        seq = '{TOL};
        run_seq(1'b0);
        chk("tol_equal_status", 32'(status), 32'd1);
        seq = '{TOL + 32'd1, 32'h0000_0000};
        run_seq(1'b0);
        chk("tol_above_count", 32'(iteration_count), 32'd1);

        start_solve();
        iter_done = 1'b1;
        tick;
        iter_done = 1'b0;
        chk("early_iter_done_done", 32'(done), 32'd1);
        chk("early_iter_done_status", 32'(status), 32'd4);
        tick;
        chk("early_iter_done_single", 32'(done), 32'd0);

        seq = '{32'h3F80_0000, 32'h0000_0001};
        run_seq(1'b1);
        chk("same_cycle_status", 32'(status), 32'd1);
        chk("same_cycle_count", 32'(iteration_count), 32'd1);

        start_solve();
        k = 0;
        feed(32'h3F80_0000, 1'b0, k, term);
        go = 1'b1;
        tick;
        go = 1'b0;
        chk("go_while_busy_busy", 32'(busy), 32'd1);
        chk("go_while_busy_count", 32'(iteration_count), 32'd1);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_done", 32'(done), 32'd1);
        chk("abort_status", 32'(status), 32'd4);
        chk("abort_count", 32'(iteration_count), 32'd1);
        tick;
        chk("abort_done_single", 32'(done), 32'd0);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_idle_status", 32'(status), 32'd4);
        chk("abort_idle_done", 32'(done), 32'd0);
        start_solve();
        k = 0;
        feed(32'h2800_0000, 1'b0, k, term);
        chk("after_abort_count", 32'(iteration_count), 32'd0);
        chk("after_abort_status", 32'(status), 32'd1);

        start_solve();
        rsnew = 32'h3F80_0000;
        rsnew_valid = 1'b1;
        tick;
        rsnew_valid = 1'b0;
        tick;
        iter_done = 1'b1;
        tick;
        iter_done = 1'b0;
        tick;
        chk("in_restart_reset_vXv1", 32'(reset_vXv1), 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk_reset_vals("mid_reset");
        repeat (4) tick;
        chk("post_reset_idle_busy", 32'(busy), 32'd0);
        chk("post_reset_idle_rst", 32'(reset_vXv1), 32'd1);
        seq = '{32'h3F80_0000, 32'h2800_0000};
        run_seq(1'b0);
        chk("post_reset_count", 32'(iteration_count), 32'd1);

`ifdef CG_STAGNATION_EN
        seq = '{32'h3F80_0000, 32'h4000_0000, 32'h4000_0000};
        run_seq(1'b0);
        chk("stall_status", 32'(status), 32'd5);
        chk("stall_count", 32'(iteration_count), 32'd2);
`endif

        for (int t = 0; t < 40; t++) begin
            seq.delete();
            for (int j = 0; j < MAXI; j++) seq.push_back(rand_val());
            run_seq(1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
